// File: rtl/register_bank_if.sv
// Bus bundle for register_bank: two combinational read ports, two write ports and the Busy flag.
// The master side drives addresses and write data. The slave side, which is the register bank, returns read data and Busy.
interface register_bank_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    A1;
    logic [AW-1:0]    A2;
    logic [WIDTH-1:0] RD1;
    logic [WIDTH-1:0] RD2;
    logic             WE3;
    logic [AW-1:0]    A3;
    logic [WIDTH-1:0] WD3;
    logic             WE4;
    logic [AW-1:0]    A4;
    logic [WIDTH-1:0] WD4;
    logic             Busy;

    modport master (
        output A1, A2, WE3, A3, WD3, WE4, A4, WD4,
        input  RD1, RD2, Busy
    );

    modport slave (
        input  A1, A2, WE3, A3, WD3, WE4, A4, WD4,
        output RD1, RD2, Busy
    );
endinterface

// File: rtl/register_bank.sv
// Multi-port register bank: 2 combinational read ports and 2 write ports. Reset starts a clear sequence that writes 0 to every entry, one entry per clock.
// Optional macro REGISTER_BANK_BYPASS_EN forwards same-cycle write data to the read ports.
module register_bank #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter bit ZERO_REG = 1
) (
    input  logic            Clk,
    input  logic            Rst,
    register_bank_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] ST_CLEAR = PW'(0);
    localparam logic [PW-1:0] ST_IDLE  = PW'(1);
    localparam logic [PW-1:0] DEPTH_W  = PW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [PW-1:0]    state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic             busy, clr_en, wr_en;
    logic             we3_ok, we4_ok;
    logic [WIDTH-1:0] mem_rd [DEPTH];
    logic [AW-1:0]    rd_addr [2];
    logic [WIDTH-1:0] rd_data [2];

    // A legal address is within range and is not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_W) && !(ZERO_REG && (a == '0));
    endfunction

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                ptr_d = ptr_q + PW'(1);
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // Rst at an edge suppresses every memory write on that edge, including the clear write.
    always_comb begin
        busy   = (state_q != ST_IDLE);
        clr_en = (state_q == ST_CLEAR) && !Rst;
        wr_en  = (state_q == ST_IDLE) && !Rst;
    end

    assign we3_ok = wr_en && bus.WE3 && addr_ok(bus.A3);
    assign we4_ok = wr_en && bus.WE4 && addr_ok(bus.A4);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [WIDTH-1:0] word_q, word_d;

            // If both write ports target this entry, port 4 has priority.
            always_comb begin
                word_d = word_q;
                if (clr_en && (ptr_q == PW'(gi))) begin
                    word_d = '0;
                end else if (we4_ok && (bus.A4 == AW'(gi))) begin
                    word_d = bus.WD4;
                end else if (we3_ok && (bus.A3 == AW'(gi))) begin
                    word_d = bus.WD3;
                end
            end

            always_ff @(posedge Clk) begin
                word_q <= word_d;
            end

            assign mem_rd[gi] = word_q;
        end
    endgenerate

    assign rd_addr[0] = bus.A1;
    assign rd_addr[1] = bus.A2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            always_comb begin
                rd_data[gi] = '0;
                if (!busy && !Rst && addr_ok(rd_addr[gi])) begin
                    rd_data[gi] = mem_rd[rd_addr[gi]];
`ifdef REGISTER_BANK_BYPASS_EN
                    if (we4_ok && (bus.A4 == rd_addr[gi])) begin
                        rd_data[gi] = bus.WD4;
                    end else if (we3_ok && (bus.A3 == rd_addr[gi])) begin
                        rd_data[gi] = bus.WD3;
                    end
`else
                    // Without forwarding, a read returns the old data until the write edge.
`endif
                end
            end
        end
    endgenerate

    assign bus.RD1  = rd_data[0];
    assign bus.RD2  = rd_data[1];
    assign bus.Busy = busy;
endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits.
REQ-002 Parameter DEPTH, default 32: number of registers; any value >= 2, power of two not required.
REQ-003 Parameter ZERO_REG, default 1: when 1, register 0 reads 0 and ignores writes.
REQ-004 Port Clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port Rst  input  1  synchronous, active-high reset; sampled on the rising edge of Clk.
REQ-006 Port A1, A2  input  $clog2(DEPTH)  read addresses.
REQ-007 Port RD1, RD2  output  WIDTH  read data, combinational.
REQ-008 Port WE3, A3, WD3  input  1 / $clog2(DEPTH) / WIDTH  write port 3: enable, address, data.
REQ-009 Port WE4, A4, WD4  input  1 / $clog2(DEPTH) / WIDTH  write port 4: enable, address, data.
REQ-010 Port Busy  output  1  high while the clear sequence runs; writes are ignored while Busy is high.

Function
REQ-011 Reads SHALL be combinational, with zero latency.
REQ-012 States: CLEAR, IDLE; the state register and the clear pointer ptr SHALL be $clog2(DEPTH)+1 bits wide.
REQ-013 Rst high at an edge SHALL force state=CLEAR, ptr=0, Busy=1, with no memory write on that edge.
REQ-014 CLEAR, Rst low, each edge SHALL set mem[ptr]=0 and ptr=ptr+1; on the edge that clears DEPTH-1, state SHALL become IDLE and Busy 0.
REQ-015 Busy SHALL be high for exactly DEPTH edges after Rst deasserts.
REQ-016 Rst reasserted mid-clear SHALL restart the clear at ptr=0.
REQ-017 While Busy=1, RD1 and RD2 SHALL read 0 and WE3/WE4 SHALL be ignored.
REQ-018 IDLE: WE3=1 SHALL write WD3 to mem[A3]; WE4=1 SHALL write WD4 to mem[A4]; both writes occur on the same edge.
REQ-019 WE3=WE4=1 with A3==A4: port 4 SHALL win and WD3 is discarded.
REQ-020 Address >= DEPTH: writes SHALL be ignored and reads SHALL return 0.
REQ-021 ZERO_REG=1: writes to address 0 SHALL be dropped and reads of address 0 SHALL return 0, regardless of bypass.
REQ-022 The read of an address being written on the same cycle SHALL follow REQ-030/REQ-031.

Reset
REQ-023 Busy SHALL be 1 from the first edge with Rst high until the clear completes.
REQ-024 RD1 and RD2 SHALL be 0 throughout reset and clear.
REQ-025 After the clear, every register SHALL hold 0.
REQ-026 Storage contents before the first reset are undefined, and the bench SHALL NOT check them.
REQ-027 No asynchronous reset path SHALL exist.

Configuration
REQ-028 The macro SHALL be REGISTER_BANK_BYPASS_EN.
REQ-029 Bypass SHALL apply only in IDLE with a legal, non-zero-register address.
REQ-030 Defined: if RDn's address matches an active write this cycle, RDn SHALL return that write data (WD4 over WD3 when both match), giving write-through forwarding.
REQ-031 Undefined: RDn SHALL return the stored value, old data, until the write edge.

Verification
REQ-032 Rst=1 for 2 cycles, then 0 -> Busy=1 for exactly 32 cycles, then 0; every address then reads 0x00000000.
REQ-033 IDLE; WE3=1, A3=5, WD3=0xDEADBEEF; next cycle A1=5 -> RD1=0xDEADBEEF; WE3=1, A3=0, WD3=0x1234 -> RD at address 0 stays 0.
REQ-034 WE3=WE4=1, A3=A4=7, WD3=0x11, WD4=0x22 -> mem[7]=0x22; separately A3=3, WD3=0xAA with A4=9, WD4=0xBB -> both stored.
REQ-035 Same cycle: WE3=1, A3=10, WD3=0x55, A2=10, with mem[10]=0x0 -> RD2=0x55 with REGISTER_BANK_BYPASS_EN, 0x0 without; both builds read 0x55 next cycle.
REQ-036 Rst pulsed at clear cycle 10 -> Busy stays high 32 more cycles; WE3=1, A3=4, WD3=0x99 issued during the clear -> mem[4] reads 0 afterwards.
REQ-037 DEPTH=20: WE3=1, A3=25, WD3=0xFF -> no register changes; A1=25 -> RD1=0.
